// File: rtl/narrow_16to8_sat_if.sv
// Valid/ready stream bundle for the 16-to-8 narrowing unit: 16-bit items with
// mode bits in, 8-bit results with a per-item overflow flag out.
interface narrow_16to8_sat_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic        in_sat;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_ovf;

  modport master (
    output in_valid, in_data, in_signed, in_sat, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_sat, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/narrow_16to8_sat.sv
// Two-stage valid/ready narrowing pipe: 16-bit values become bytes, saturated or
// wrapped when out of range, with sticky and saturating-count overflow statistics.
module narrow_16to8_sat (
  input  logic                      clk,
  input  logic                      rst,
  narrow_16to8_sat_if.slave         bus,
  input  logic                      clr_stat,
  output logic                      sticky_ovf,
  output logic [7:0]                ovf_count
);
  localparam int STAGES = 2;

  // S1 keeps only what the narrowing step needs: low byte, sign bit, modes, fit flag.
  typedef struct packed {
    logic [7:0] lo;
    logic       msb;
    logic       sgn;
    logic       sat;
    logic       fits;
  } s1_t;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
  } s2_t;

  logic [STAGES-1:0] vld_pipe;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic              s1_ld, s2_ld, in_fire, out_fire, ovf_evt;
  logic [7:0]        cnt_base;

  assign s2_ld        = !vld_pipe[1] | bus.out_ready;
  assign s1_ld        = !vld_pipe[0] | s2_ld;
  assign bus.in_ready = !rst & s1_ld;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = vld_pipe[1] & bus.out_ready;

  always_comb begin
    s1_d.lo   = bus.in_data[7:0];
    s1_d.msb  = bus.in_data[15];
    s1_d.sgn  = bus.in_signed;
    s1_d.sat  = bus.in_sat;
    s1_d.fits = bus.in_signed ? ((&bus.in_data[15:7]) | ~(|bus.in_data[15:7]))
                              : ~(|bus.in_data[15:8]);
  end

  // Wrap mode keeps the low byte even when flagged as overflow.
  always_comb begin
    s2_d.data = s1_q.lo;
    s2_d.ovf  = !s1_q.fits;
    if (!s1_q.fits && s1_q.sat)
      s2_d.data = !s1_q.sgn ? 8'hFF : (s1_q.msb ? 8'h80 : 8'h7F);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_ld) vld_pipe[0] <= bus.in_valid;
      if (in_fire) s1_q <= s1_d;
      if (s2_ld) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) s2_q <= s2_d;
      end
    end
  end

  assign bus.out_valid = vld_pipe[1];
  assign bus.out_data  = s2_q.data;
  assign bus.out_ovf   = s2_q.ovf;

  // A clear in the same cycle as an overflow event is applied first.
  assign ovf_evt  = out_fire & s2_q.ovf;
  assign cnt_base = clr_stat ? 8'd0 : ovf_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= 8'd0;
    end else begin
      sticky_ovf <= (sticky_ovf & ~clr_stat) | ovf_evt;
      ovf_count  <= (ovf_evt && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
    end
  end
endmodule

// File: tb/tb_narrow_16to8_sat.sv
// Bench for narrow_16to8_sat: directed scenarios plus random traffic against a
// queue-based reference model of the narrowing rules and statistics.
module tb_narrow_16to8_sat;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_stat = 1'b0;
  logic       sticky_ovf;
  logic [7:0] ovf_count;

  narrow_16to8_sat_if bus();

  narrow_16to8_sat dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_stat(clr_stat),
    .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] v; int cyc; } exp_t;
  typedef struct { logic [8:0] got; logic [8:0] exp; bit miss; int lat; } rec_t;

  exp_t exp_q[$];
  rec_t rec_q[$];
  int   cyc = 0;
  int   mcnt = 0;
  bit   msticky = 0;
  bit   last_acc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference: {ovf, byte} from integer range arithmetic.
  function automatic logic [8:0] model(logic [15:0] d, logic sgn, logic sat);
    int v;
    bit fits;
    logic [7:0] r;
    v = int'(d);
    if (sgn && v > 32767) v = v - 65536;
    fits = sgn ? (v >= -128 && v <= 127) : (v <= 255);
    r = d[7:0];
    if (!fits && sat) begin
      if (!sgn)        r = 8'd255;
      else if (v > 0)  r = 8'd127;
      else             r = 8'h80;
    end
    return {!fits, r};
  endfunction

  task automatic set_in(bit v, logic [15:0] d, bit s, bit t);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_signed = s;
    bus.in_sat    = t;
  endtask

  // One clock: record handshakes into the model, then advance past the edge.
  task automatic step();
    exp_t e;
    rec_t r;
    bit acc, ofire, ev;
    #1;
    acc   = bus.in_valid && bus.in_ready;
    ofire = bus.out_valid && bus.out_ready;
    ev    = 0;
    if (rst) begin
      exp_q.delete();
      mcnt = 0; msticky = 0; acc = 0;
    end else begin
      if (ofire) begin
        r.got = {bus.out_ovf, bus.out_data};
        if (exp_q.size() == 0) begin
          r.miss = 1; r.exp = '0; r.lat = 0;
        end else begin
          e = exp_q.pop_front();
          r.miss = 0; r.exp = e.v; r.lat = cyc - e.cyc; ev = e.v[8];
        end
        rec_q.push_back(r);
      end
      if (clr_stat) begin mcnt = 0; msticky = 0; end
      if (ev) begin msticky = 1; if (mcnt < 255) mcnt++; end
      if (acc) begin
        e.v = model(bus.in_data, bus.in_signed, bus.in_sat);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
    last_acc = acc;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    bus.in_valid  = 0;
    bus.out_ready = 1;
    for (int n = 0; n < 50 && exp_q.size() > 0; n++) step();
    step(); step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout: %0d items still pending, want 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1; clr_stat = 0;
    set_in(0, 16'h0, 0, 0);
    bus.out_ready = 1;
    step();
    rst = 0;
    rec_q.delete();
  endtask

  task automatic test_reset();
    rst = 1; clr_stat = 0;
    set_in(1, 16'h1234, 0, 1);
    bus.out_ready = 1;
    step(); step();
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_ovf, sticky_ovf, ovf_count} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h ovf=%b sticky=%b cnt=%0d, want all 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_ovf, sticky_ovf, ovf_count);
    end
    rst = 0;
    bus.in_valid = 0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_valid: got %b want 0", bus.out_valid);
    end
    rec_q.delete();
  endtask

  task automatic test_signed_sat();
    logic [15:0] din [4] = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F};
    logic [8:0]  want[4] = '{9'h07F, 9'h17F, 9'h080, 9'h180};
    rec_t r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, din[i], 1, 1);
      step();
    end
    drain();
    n_tests++;
    if (rec_q.size() != 4) begin
      n_fail++; $display("FAIL signed_count: got %0d outputs want 4", rec_q.size());
    end
    for (int i = 0; i < 4 && rec_q.size() > 0; i++) begin
      r = rec_q.pop_front();
      n_tests++;
      if (r.got !== want[i] || r.lat != 2) begin
        n_fail++; $display("FAIL signed_sat[%0d]: got %h lat %0d want %h lat 2", i, r.got, r.lat, want[i]);
      end
    end
    n_tests++;
    if (ovf_count !== 8'd2 || sticky_ovf !== 1'b1) begin
      n_fail++; $display("FAIL signed_stats: cnt=%0d sticky=%b want 2/1", ovf_count, sticky_ovf);
    end
  endtask

  task automatic test_unsigned_wrap();
    logic [15:0] din [4] = '{16'h00FF, 16'h0100, 16'h1234, 16'hFE10};
    bit          sgn [4] = '{0, 0, 0, 1};
    bit          sat [4] = '{1, 1, 0, 0};
    logic [8:0]  want[4] = '{9'h0FF, 9'h1FF, 9'h134, 9'h110};
    rec_t r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, din[i], sgn[i], sat[i]);
      step();
    end
    drain();
    n_tests++;
    if (rec_q.size() != 4) begin
      n_fail++; $display("FAIL wrap_count: got %0d outputs want 4", rec_q.size());
    end
    for (int i = 0; i < 4 && rec_q.size() > 0; i++) begin
      r = rec_q.pop_front();
      n_tests++;
      if (r.got !== want[i]) begin
        n_fail++; $display("FAIL unsigned_wrap[%0d]: got %h want %h", i, r.got, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 1;
    bit have = 0;
    logic [8:0] hold = '0;
    rec_t r;
    do_reset();
    bus.out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      set_in(1, 16'(idx), 0, 1);
      step();
      if (last_acc) idx++;
      if (bus.out_valid) begin
        if (!have) begin
          hold = {bus.out_ovf, bus.out_data}; have = 1;
        end else begin
          n_tests++;
          if ({bus.out_ovf, bus.out_data} !== hold) begin
            n_fail++; $display("FAIL stall_stable: got %h want %h", {bus.out_ovf, bus.out_data}, hold);
          end
        end
      end
    end
    n_tests++;
    if (idx != 3 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: accepted %0d rdy=%b want 2 rdy=0", idx - 1, bus.in_ready);
    end
    bus.out_ready = 1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_comb: got %b want 1", bus.in_ready);
    end
    for (int n = 0; n < 50 && idx <= 5; n++) begin
      set_in(1, 16'(idx), 0, 1);
      step();
      if (last_acc) idx++;
    end
    drain();
    n_tests++;
    if (rec_q.size() != 5) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs want 5", rec_q.size());
    end
    for (int i = 1; i <= 5 && rec_q.size() > 0; i++) begin
      r = rec_q.pop_front();
      n_tests++;
      if (r.got !== 9'(i) || r.miss) begin
        n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, r.got, 9'(i));
      end
    end
  endtask

  task automatic test_stats();
    int sent = 0;
    do_reset();
    for (int n = 0; n < 400 && sent < 300; n++) begin
      set_in(1, 16'h0200, 0, 1);
      step();
      if (last_acc) sent++;
    end
    drain();
    n_tests++;
    if (ovf_count !== 8'd255 || sticky_ovf !== 1'b1 || mcnt != 255) begin
      n_fail++; $display("FAIL stats_sat: cnt=%0d sticky=%b want 255/1", ovf_count, sticky_ovf);
    end
    clr_stat = 1;
    step();
    clr_stat = 0;
    n_tests++;
    if (ovf_count !== 8'd0 || sticky_ovf !== 1'b0) begin
      n_fail++; $display("FAIL stats_clear: cnt=%0d sticky=%b want 0/0", ovf_count, sticky_ovf);
    end
    bus.out_ready = 0;
    set_in(1, 16'h0200, 0, 1);
    step();
    bus.in_valid = 0;
    for (int n = 0; n < 10 && !bus.out_valid; n++) step();
    clr_stat = 1;
    bus.out_ready = 1;
    step();
    clr_stat = 0;
    n_tests++;
    if (ovf_count !== 8'd1 || sticky_ovf !== 1'b1 || mcnt != 1) begin
      n_fail++; $display("FAIL stats_clear_event: cnt=%0d sticky=%b want 1/1", ovf_count, sticky_ovf);
    end
    rec_q.delete();
  endtask

  task automatic test_reset_mid();
    rec_t r;
    do_reset();
    set_in(1, 16'h0300, 0, 1);
    step();
    drain();
    bus.out_ready = 0;
    set_in(1, 16'h0011, 0, 1); step();
    set_in(1, 16'h0022, 0, 1); step();
    rst = 1;
    step();
    rst = 0;
    bus.in_valid = 0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || ovf_count !== 8'd0 || sticky_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: vld=%b cnt=%0d sticky=%b want 0/0/0",
                         bus.out_valid, ovf_count, sticky_ovf);
    end
    rec_q.delete();
    bus.out_ready = 1;
    set_in(1, 16'h0005, 1, 1);
    step();
    drain();
    n_tests++;
    if (rec_q.size() != 1) begin
      n_fail++; $display("FAIL reset_mid_count: got %0d outputs want 1", rec_q.size());
    end else begin
      r = rec_q.pop_front();
      n_tests++;
      if (r.got !== 9'h005) begin
        n_fail++; $display("FAIL reset_mid_data: got %h want 005", r.got);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [7:0] a;
    rec_t r;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      set_in(1, {{8{a[7]}}, a}, 1, 1);
      step();
    end
    drain();
    n_tests++;
    if (rec_q.size() != 256) begin
      n_fail++; $display("FAIL rt_count: got %0d outputs want 256", rec_q.size());
    end
    for (int i = 0; i < 256 && rec_q.size() > 0; i++) begin
      r = rec_q.pop_front();
      n_tests++;
      if (r.got !== {1'b0, 8'(i)} || r.lat != 2) begin
        n_fail++; $display("FAIL roundtrip[%0d]: got %h lat %0d want %h lat 2", i, r.got, r.lat, {1'b0, 8'(i)});
      end
    end
    n_tests++;
    if (ovf_count !== 8'd0) begin
      n_fail++; $display("FAIL rt_stats: cnt=%0d want 0", ovf_count);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    logic [15:0] d;
    rec_t r;
    do_reset();
    d = 16'($urandom);
    for (int n = 0; n < 3000 && sent < 300; n++) begin
      set_in($urandom_range(0, 3) != 0, d, 1'($urandom), 1'($urandom));
      bus.out_ready = $urandom_range(0, 3) != 0;
      clr_stat = $urandom_range(0, 31) == 0;
      step();
      if (last_acc) begin
        sent++;
        case ($urandom_range(0, 3))
          0: d = 16'($urandom);
          1: d = 16'(int'($urandom_range(0, 511)) - 256);
          2: d = 16'($urandom_range(0, 300));
          default: d = {8'hFF, 8'($urandom)};
        endcase
      end
      n_tests++;
      if (ovf_count !== 8'(mcnt) || sticky_ovf !== msticky) begin
        n_fail++; $display("FAIL rand_stats: cnt=%0d sticky=%b want %0d/%b", ovf_count, sticky_ovf, mcnt, msticky);
      end
    end
    clr_stat = 0;
    drain();
    n_tests++;
    if (rec_q.size() != 300) begin
      n_fail++; $display("FAIL rand_count: got %0d outputs want 300", rec_q.size());
    end
    while (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      n_tests++;
      if (r.miss || r.got !== r.exp) begin
        n_fail++; $display("FAIL rand_data: got %h want %h miss=%b", r.got, r.exp, r.miss);
      end
    end
  endtask

  initial begin
    set_in(0, 16'h0, 0, 0);
    bus.out_ready = 1;
    test_reset();
    test_signed_sat();
    test_unsigned_wrap();
    test_backpressure();
    test_stats();
    test_reset_mid();
    test_roundtrip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
